// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline: occupancy sizing and saturating add.
package elastic_pipe_pkg;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Unsigned add clamped to max_val; widths up to 32 bits are supported.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a valid bit plus a payload register.
// Priority is reset, then kill (flush), then hold (stall), then advance.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             adv,
  input  logic             kill,
  input  logic             hold,
  output logic             v,
  output logic [WIDTH-1:0] data
);

  logic             v_reg;
  logic [WIDTH-1:0] data_reg;

  // Slot register: take the upstream word whenever this slot is allowed to move.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg    <= 1'b0;
      data_reg <= '0;
    end else if (kill) begin
      v_reg    <= 1'b0;
    end else if (!hold && adv) begin
      v_reg    <= up_valid;
      data_reg <= up_data;
    end
  end

  assign v    = v_reg;
  assign data = data_reg;

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready pipeline with bubble collapsing, global stall and
// flush, a registered occupancy count and a saturating flush-drop counter.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  input  logic                               stall,
  input  logic                               flush,
  output logic [clog2_safe(DEPTH+1)-1:0]     occupancy,
  output logic [CNTW-1:0]                    drop_count
);

  localparam int OCCW = clog2_safe(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             in_hs;
  logic             out_hs;
  logic [OCCW-1:0]  pop;
  logic [OCCW-1:0]  occupancy_reg, occupancy_next;
  logic [CNTW-1:0]  drop_count_reg, drop_count_next;

  // Ready ripples from the consumer back toward the input; an empty slot is
  // always ready, which is what lets bubbles collapse under backpressure.
  always_comb begin
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !v[k] | rdy[k+1];
    end
  end

  assign in_ready  = rdy[0] & !stall & !flush & !rst;
  assign out_valid = v[DEPTH-1] & !stall & !rst;
  assign out_data  = data[DEPTH-1];
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             up_v;
      logic [WIDTH-1:0] up_d;
      if (gi == 0) begin : g_head
        assign up_v = in_hs;
        assign up_d = in_data;
      end else begin : g_body
        assign up_v = v[gi-1];
        assign up_d = data[gi-1];
      end
      pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .up_valid (up_v),
        .up_data  (up_d),
        .adv      (rdy[gi]),
        .kill     (flush),
        .hold     (stall),
        .v        (v[gi]),
        .data     (data[gi])
      );
    end
  endgenerate

  // Count of valid slots, used for the flush drop tally and the sanity check.
  always_comb begin
    pop = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pop = pop + OCCW'(v[k]);
    end
  end

  // Next-state for occupancy and drop counter; a word leaving during the
  // flush cycle is delivered, not dropped.
  always_comb begin
    occupancy_next  = occupancy_reg + OCCW'(in_hs) - OCCW'(out_hs);
    drop_count_next = drop_count_reg;
    if (flush) begin
      occupancy_next  = '0;
      drop_count_next = CNTW'(sat_add(32'(drop_count_reg),
                                      32'(pop - OCCW'(out_hs)),
                                      32'({CNTW{1'b1}})));
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      occupancy_reg  <= occupancy_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // Occupancy must stay within range and agree with the valid bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occupancy_reg <= OCCW'(DEPTH) && occupancy_reg == pop);
    end
  end

  assign occupancy  = occupancy_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: a DEPTH=4/CNTW=2 instance for the main
// behaviour and drop saturation, plus a DEPTH=1 instance for the degenerate case.
module tb_elastic_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  occupancy;
  logic [1:0]  drop_count;

  logic        b_in_valid = 1'b0, b_out_ready = 1'b0, b_stall = 1'b0, b_flush = 1'b0;
  logic [31:0] b_in_data = '0;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [0:0]  b_occupancy;
  logic [15:0] b_drop_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  elastic_pipe #(.WIDTH(32), .DEPTH(4), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .stall(stall), .flush(flush),
    .occupancy(occupancy), .drop_count(drop_count)
  );

  elastic_pipe #(.WIDTH(32), .DEPTH(1), .CNTW(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .stall(b_stall), .flush(b_flush),
    .occupancy(b_occupancy), .drop_count(b_drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Push n consecutive words into an empty pipe (out_ready low keeps them).
  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_w;
  int          acc;
  int          drained;

  initial begin
    // Reset with a word offered
    in_valid = 1'b1;
    in_data  = 32'hAA;
    settle();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    tick();
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_in_ready_2", 64'(in_ready), 64'd0);

    // Latency / throughput: 0x11, 0x22, 0x33
    rst       = 1'b0;
    out_ready = 1'b1;
    in_data   = 32'h11;
    settle();
    chk("first_accept", 64'(in_ready), 64'd1);
    tick();
    in_data = 32'h22;
    tick();
    in_data = 32'h33;
    chk("lat_early_out_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("lat_occ_peak", 64'(occupancy), 64'd3);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("lat_w0_valid", 64'(out_valid), 64'd1);
    chk("lat_w0_data", 64'(out_data), 64'h11);
    tick();
    chk("lat_w1_data", 64'(out_data), 64'h22);
    tick();
    chk("lat_w2_data", 64'(out_data), 64'h33);
    tick();
    chk("lat_empty_valid", 64'(out_valid), 64'd0);
    chk("lat_empty_occ", 64'(occupancy), 64'd0);

    // Backpressure: fill until in_ready drops
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      settle();
      if (!in_ready) break;
      q.push_back(in_data);
      acc++;
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_occ_full", 64'(occupancy), 64'd4);
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    in_data   = 32'hB0;
    settle();
    chk("bp_in_ready_same_cycle", 64'(in_ready), 64'd1);
    exp_w = q.pop_front();
    chk("bp_head", 64'(out_data), 64'(exp_w));
    q.push_back(32'hB0);
    tick();
    in_valid = 1'b0;
    drained  = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      if (out_valid) begin
        exp_w = (q.size() != 0) ? q.pop_front() : 32'hDEAD;
        chk("bp_order", 64'(out_data), 64'(exp_w));
        drained++;
      end
      tick();
    end
    chk("bp_drained", 64'(drained), 64'd4);

    // Stall with two words parked at the output end
    out_ready = 1'b0;
    push_n(2, 32'hC1);
    repeat (3) tick();
    stall     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hCC;
    settle();
    chk("stall_out_valid", 64'(out_valid), 64'd0);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_occ", 64'(occupancy), 64'd2);
      chk("stall_data", 64'(out_data), 64'hC1);
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    settle();
    chk("stall_resume_valid", 64'(out_valid), 64'd1);
    chk("stall_resume_w0", 64'(out_data), 64'hC1);
    tick();
    chk("stall_resume_w1", 64'(out_data), 64'hC2);
    tick();
    chk("stall_done_occ", 64'(occupancy), 64'd0);

    // Flush with three words, last stage valid, consumer ready
    out_ready = 1'b0;
    push_n(3, 32'hD1);
    repeat (3) tick();
    chk("flush_pre_occ", 64'(occupancy), 64'd3);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hEE;
    settle();
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd1);
    chk("flush_out_data", 64'(out_data), 64'hD1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_drop", 64'(drop_count), 64'd2);
    chk("flush_out_valid_after", 64'(out_valid), 64'd0);
    repeat (5) tick();
    chk("flush_no_entry_valid", 64'(out_valid), 64'd0);
    chk("flush_no_entry_occ", 64'(occupancy), 64'd0);

    // Drop counter saturation (CNTW=2)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_drop", 64'(drop_count), 64'd0);
    out_ready = 1'b0;
    push_n(4, 32'hF0);
    chk("sat_full_occ", 64'(occupancy), 64'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_drop_1", 64'(drop_count), 64'd3);
    push_n(4, 32'hF8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_drop_2", 64'(drop_count), 64'd3);
    chk("sat_occ", 64'(occupancy), 64'd0);

    // Flush beats stall
    push_n(2, 32'h70);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    chk("flush_over_stall_occ", 64'(occupancy), 64'd0);

    // DEPTH=1: single register slice
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_in_data   = 32'h51;
    settle();
    chk("d1_in_ready", 64'(b_in_ready), 64'd1);
    chk("d1_empty_valid", 64'(b_out_valid), 64'd0);
    tick();
    b_in_data = 32'h52;
    settle();
    chk("d1_w0_valid", 64'(b_out_valid), 64'd1);
    chk("d1_w0_data", 64'(b_out_data), 64'h51);
    chk("d1_ready_full_passthru", 64'(b_in_ready), 64'd1);
    tick();
    b_in_data = 32'h53;
    chk("d1_w1_data", 64'(b_out_data), 64'h52);
    tick();
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    settle();
    chk("d1_w2_data", 64'(b_out_data), 64'h53);
    chk("d1_full_blocked", 64'(b_in_ready), 64'd0);
    chk("d1_occ", 64'(b_occupancy), 64'd1);
    b_out_ready = 1'b1;
    tick();
    chk("d1_drained", 64'(b_out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
